// File: rtl/ssdisp_pkg.sv
// ---------------------------------------------------------------------------
// ssdisp_pkg
// Shared types and constants for the seven-segment decimal display block.
//   state_t     : conversion FSM states (IDLE, CONVERT, DONE)
//   SEG_*       : active-high segment codes, bit order g..a
//   bcd_digits(): decimal digits needed for a binary word of a given width
// ---------------------------------------------------------------------------
package ssdisp_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        DONE    = 2'd2
    } state_t;

    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_MINUS = 7'h40;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    // ceil(width * log10(2)), using log10(2) ~= 0.30103 in fixed point.
    function automatic int bcd_digits(input int width);
        return (width * 30103 + 99999) / 100000;
    endfunction

endpackage

// File: rtl/bcd_to_7seg.sv
// ---------------------------------------------------------------------------
// bcd_to_7seg
// Combinational decoder from one BCD nibble to a seven-segment code.
//   bcd : 4-bit BCD digit (10..15 decode to blank)
//   seg : segment code, bits 6:0 = g..a, active high
// ---------------------------------------------------------------------------
module bcd_to_7seg
    import ssdisp_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    always_comb begin
        // NOTE: default assigned first so every path drives seg; no latch.
        seg = SEG_BLANK;
        case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/ssdata_decimal_display.sv
// ---------------------------------------------------------------------------
// ssdata_decimal_display
// Shows the core's seven-segment data word in decimal. A sequential
// double-dabble engine (one bit per clock) runs only when the word or the
// display modes change, so the digits stay steady between core writes.
//   clk       : system clock
//   rst       : asynchronous, active-high reset
//   value     : word to display, sampled only in IDLE
//   signed_en : 1 = two's complement, 0 = unsigned
//   blank_lz  : 1 = suppress leading zeros
//   seg       : digit i = seg[8i+7:8i]; bit7 = dp, bits6:0 = g..a; digit 0 rightmost
//   busy      : high while converting (CONVERT and DONE)
//   updated   : one-cycle pulse on the edge seg is loaded
//   overflow  : value (with its sign) needs more than DIGITS digits
// ---------------------------------------------------------------------------
module ssdata_decimal_display
    import ssdisp_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int DIGITS = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [WIDTH-1:0]    value,
    input  logic                signed_en,
    input  logic                blank_lz,
    output logic [DIGITS*8-1:0] seg,
    output logic                busy,
    output logic                updated,
    output logic                overflow
);

    // Engine never holds fewer nibbles than there are physical digits.
    localparam int BCD_MIN = bcd_digits(WIDTH);
    localparam int BCD_N   = (BCD_MIN > DIGITS) ? BCD_MIN : DIGITS;
    localparam int CNT_W   = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_t               state, state_next;
    logic [WIDTH-1:0]     last_value;
    logic                 last_signed;
    logic                 last_blank;
    logic                 force_conv;
    logic                 neg;
    logic [WIDTH-1:0]     mag;
    logic [4*BCD_N-1:0]   bcd, bcd_adj;
    logic [CNT_W-1:0]     cnt;
    logic                 change_seen;

    logic [6:0]           dig_code [DIGITS];
    logic [DIGITS*8-1:0]  seg_next;
    logic                 ovf_next;
    logic                 high_nz;
    logic [7:0]           digit;
    int                   sig_digits;

    assign busy = (state != IDLE);

    assign change_seen = force_conv | (value != last_value)
                       | (signed_en != last_signed) | (blank_lz != last_blank);

    // ---------------- FSM ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (change_seen) state_next = CONVERT;
            CONVERT: if (cnt == CNT_W'(WIDTH - 1)) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // ---------------- double-dabble add-3 step ----------------
    always_comb begin
        bcd_adj = bcd;
        for (int i = 0; i < BCD_N; i++)
            if (bcd[4*i +: 4] >= 4'd5)
                bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end

    // ---------------- digit decoders ----------------
    for (genvar g = 0; g < DIGITS; g++) begin : g_dec
        bcd_to_7seg u_dec (
            .bcd (bcd[4*g +: 4]),
            .seg (dig_code[g])
        );
    end

    // ---------------- sign, blanking and overflow ----------------
    always_comb begin
        sig_digits = 1;
        for (int i = 0; i < BCD_N; i++)
            if (bcd[4*i +: 4] != 4'd0) sig_digits = i + 1;

        high_nz = 1'b0;
        for (int i = DIGITS; i < BCD_N; i++)
            high_nz = high_nz | (bcd[4*i +: 4] != 4'd0);

        // A negative number with DIGITS significant digits leaves no room for the minus.
        ovf_next = high_nz | (neg & (sig_digits == DIGITS));

        seg_next = '0;
        digit    = '0;
        for (int i = 0; i < DIGITS; i++) begin
            digit = {1'b0, dig_code[i]};
            if (ovf_next) begin
                // Truncated display: dp on the leftmost digit flags it.
                if (i == DIGITS - 1)
                    digit = {1'b1, (neg ? SEG_MINUS : dig_code[i])};
            end else if (last_blank) begin
                if (i >= sig_digits)
                    digit = (neg && i == sig_digits) ? {1'b0, SEG_MINUS} : 8'h00;
            end else if (neg && i == DIGITS - 1) begin
                digit = {1'b0, SEG_MINUS};
            end
            seg_next[8*i +: 8] = digit;
        end
    end

    // ---------------- datapath ----------------
    // NOTE: every register here is a handful of flops, not a memory, so all of
    // them take the async reset; force_conv=1 makes the first edge convert.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_value  <= '0;
            last_signed <= 1'b0;
            last_blank  <= 1'b0;
            force_conv  <= 1'b1;
            neg         <= 1'b0;
            mag         <= '0;
            bcd         <= '0;
            cnt         <= '0;
            seg         <= '0;
            updated     <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            // NOTE: non-blocking everywhere so all state updates see pre-edge values.
            updated <= 1'b0;
            case (state)
                IDLE: begin
                    if (change_seen) begin
                        last_value  <= value;
                        last_signed <= signed_en;
                        last_blank  <= blank_lz;
                        force_conv  <= 1'b0;
                        neg         <= signed_en & value[WIDTH-1];
                        // Negating the most negative value wraps to its magnitude.
                        mag         <= (signed_en & value[WIDTH-1]) ? (~value + WIDTH'(1)) : value;
                        bcd         <= '0;
                        cnt         <= '0;
                    end
                end
                CONVERT: begin
                    {bcd, mag} <= {bcd_adj[4*BCD_N-2:0], mag, 1'b0};
                    cnt        <= cnt + CNT_W'(1);
                end
                DONE: begin
                    seg      <= seg_next;
                    updated  <= 1'b1;
                    overflow <= ovf_next;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ssdata_decimal_display.sv
// ---------------------------------------------------------------------------
// tb_ssdata_decimal_display
// Directed and random stimulus for ssdata_decimal_display. Expected digits
// come from an arithmetic model: the magnitude is split into decimal digits
// by repeated division, then sign/blank/overflow rules are applied.
// ---------------------------------------------------------------------------
module tb_ssdata_decimal_display;

    localparam int LAT = 34;   // edges from sampling edge to seg load, inclusive

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] value;
    logic        signed_en;
    logic        blank_lz;
    logic [63:0] seg;
    logic        busy;
    logic        updated;
    logic        overflow;

    int n_checks = 0;
    int n_pass   = 0;

    ssdata_decimal_display dut (
        .clk       (clk),
        .rst       (rst),
        .value     (value),
        .signed_en (signed_en),
        .blank_lz  (blank_lz),
        .seg       (seg),
        .busy      (busy),
        .updated   (updated),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    function automatic logic [6:0] code_of(input int d);
        case (d)
            0: return 7'h3F;  1: return 7'h06;  2: return 7'h5B;  3: return 7'h4F;
            4: return 7'h66;  5: return 7'h6D;  6: return 7'h7D;  7: return 7'h07;
            8: return 7'h7F;  9: return 7'h6F;
            default: return 7'h00;
        endcase
    endfunction

    // Reference: decimal digits of |value|, then the display rules.
    function automatic void model(input logic [31:0] v, input logic se, input logic bl,
                                  output logic [63:0] s, output logic o);
        longint unsigned m;
        int              d [10];
        int              nd;
        bit              ng;
        logic [7:0]      c;
        ng = se && v[31];
        m  = ng ? (64'h1_0000_0000 - {32'h0, v}) : {32'h0, v};
        nd = 1;
        for (int k = 0; k < 10; k++) begin
            d[k] = int'(m % 10);
            m    = m / 10;
            if (d[k] != 0) nd = k + 1;
        end
        o = (nd > 8) || (ng && nd == 8);
        s = '0;
        for (int k = 0; k < 8; k++) begin
            c = {1'b0, code_of(d[k])};
            if (o) begin
                if (k == 7) c = {1'b1, (ng ? 7'h40 : code_of(d[k]))};
            end else if (bl) begin
                if (k >= nd) c = (ng && k == nd) ? 8'h40 : 8'h00;
            end else if (ng && k == 7) begin
                c = 8'h40;
            end
            s[8*k +: 8] = c;
        end
    endfunction

    // Counts posedges until updated is seen; also reports whether seg stayed put.
    task automatic wait_update(output int edges, output bit got, output bit stable);
        logic [63:0] seg0;
        seg0   = seg;
        edges  = 0;
        got    = 1'b0;
        stable = 1'b1;
        while (!got && edges < 200) begin
            @(posedge clk); #1;
            edges++;
            if (updated) got = 1'b1;
            else if (seg !== seg0) stable = 1'b0;
        end
    endtask

    task automatic run_case(input string tag, input logic [31:0] v, input logic se, input logic bl);
        logic [63:0] exp_s;
        logic        exp_o;
        int          edges;
        bit          got, stable;
        @(negedge clk);
        value = v; signed_en = se; blank_lz = bl;
        model(v, se, bl, exp_s, exp_o);
        wait_update(edges, got, stable);
        check({tag, "_updated"}, got, 1'b1);
        check({tag, "_latency"}, edges, LAT);
        check({tag, "_seg"}, seg, exp_s);
        check({tag, "_ovf"}, overflow, exp_o);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_hold"}, stable, 1'b1);
        @(posedge clk); #1;
        check({tag, "_pulse"}, updated, 1'b0);
    endtask

    initial begin
        logic [63:0] exp_s;
        logic        exp_o;
        logic [31:0] rv, prev_v;
        logic        rse, rbl, prev_se, prev_bl;
        int          edges, pulses;
        bit          got, stable, quiet;

        // ---- 1: reset state and first unconditional conversion ----
        rst = 1'b1; value = '0; signed_en = 1'b0; blank_lz = 1'b1;
        #3;
        check("rst_seg", seg, 64'h0);
        check("rst_busy", busy, 1'b0);
        check("rst_updated", updated, 1'b0);
        check("rst_ovf", overflow, 1'b0);
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        check("t1_busy_start", busy, 1'b1);
        wait_update(edges, got, stable);
        check("t1_latency", edges + 1, LAT);
        check("t1_seg", seg, 64'h0000_0000_0000_003F);
        check("t1_ovf", overflow, 1'b0);

        // ---- 2..4: spec examples with literal expectations ----
        run_case("t2", 32'd12345678, 1'b0, 1'b1);
        check("t2_lit", seg, 64'h065B_4F66_6D7D_077F);
        run_case("t3", 32'hFFFF_FFFF, 1'b0, 1'b1);
        check("t3_lit", seg, 64'hEF66_6F7D_075B_6F6D);
        check("t3_ovf_lit", overflow, 1'b1);
        run_case("t4", 32'hFFFF_FFFF, 1'b1, 1'b1);
        check("t4_lit", seg, 64'h0000_0000_0000_4006);

        // ---- mode change only, then boundary values ----
        run_case("noblank_neg", 32'hFFFF_FFFF, 1'b1, 1'b0);
        check("noblank_neg_lit", seg, 64'h403F_3F3F_3F3F_3F06);
        run_case("min_neg", 32'h8000_0000, 1'b1, 1'b1);
        run_case("max8", 32'd99999999, 1'b0, 1'b0);
        run_case("nine_digits", 32'd100000000, 1'b0, 1'b1);
        run_case("neg7", -32'sd9999999, 1'b1, 1'b1);
        check("neg7_lit", seg, 64'h406F_6F6F_6F6F_6F6F);
        run_case("neg8_ovf", -32'sd10000000, 1'b1, 1'b1);
        run_case("zero_noblank", 32'd0, 1'b0, 1'b0);

        // ---- unchanged inputs must not restart the engine ----
        quiet = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk); #1;
            if (busy || updated) quiet = 1'b0;
        end
        check("idle_quiet", quiet, 1'b1);

        // ---- 5: change during CONVERT ----
        @(negedge clk);
        value = 32'd5; signed_en = 1'b0; blank_lz = 1'b1;
        repeat (11) @(posedge clk);
        @(negedge clk);
        value = 32'd7;
        wait_update(edges, got, stable);
        check("t5_first_updated", got, 1'b1);
        check("t5_first_seg", seg, 64'h0000_0000_0000_006D);
        wait_update(edges, got, stable);
        check("t5_second_updated", got, 1'b1);
        check("t5_second_latency", edges, LAT);
        check("t5_final_seg", seg, 64'h0000_0000_0000_0007);
        pulses = 0; quiet = 1'b1;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk); #1;
            if (updated) pulses++;
            if (seg !== 64'h7) quiet = 1'b0;
        end
        check("t5_no_more_pulses", pulses, 0);
        check("t5_seg_stable", quiet, 1'b1);

        // ---- 6: reset mid-CONVERT ----
        @(negedge clk);
        value = 32'd4321;
        repeat (12) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("t6_seg_cleared", seg, 64'h0);
        check("t6_busy_cleared", busy, 1'b0);
        check("t6_ovf_cleared", overflow, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        model(32'd4321, 1'b0, 1'b1, exp_s, exp_o);
        wait_update(edges, got, stable);
        check("t6_updated", got, 1'b1);
        check("t6_latency", edges, LAT);
        check("t6_seg", seg, exp_s);

        // ---- random words and modes ----
        prev_v = value; prev_se = signed_en; prev_bl = blank_lz;
        for (int i = 0; i < 20; i++) begin
            rv  = $urandom;
            rse = 1'($urandom_range(0, 1));
            rbl = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) rv = $urandom_range(0, 999);
            if ($urandom_range(0, 3) == 0) rv = -$urandom_range(1, 99999);
            if (rv == prev_v && rse == prev_se && rbl == prev_bl) rv = rv ^ 32'h1;
            run_case($sformatf("rand%0d", i), rv, rse, rbl);
            prev_v = rv; prev_se = rse; prev_bl = rbl;
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
